fwvexrisc_wb_timer: RTL and testbench

//  Wishbone B4 classic target: RISC-V style machine timer (64-bit mtime/mtimecmp) with prescaler.

---
 rtl/fwvexrisc_wb_timer.sv | 168 ++++++++++++++++
 tb/tb_fwvexrisc_wb_timer.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fwvexrisc_wb_timer.sv
// Wishbone B4 classic machine timer: 64-bit mtime/mtimecmp, prescaler, level irq; one wait state per access.
// Define FWVEXRISC_WB_TIMER_SNAPSHOT_EN to latch mtime[63:32] on MTIME_LO reads for coherent LO-then-HI reads.
module fwvexrisc_wb_timer #(
    parameter int unsigned ADR_WIDTH = 32,
    parameter int unsigned PRESCALE_W = 16,
    parameter logic [PRESCALE_W-1:0] PRESCALE_RST = '0
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [ADR_WIDTH-1:0] t_adr,
    input  logic [31:0]          t_dat_w,
    output logic [31:0]          t_dat_r,
    input  logic                 t_cyc,
    input  logic                 t_stb,
    input  logic [3:0]           t_sel,
    input  logic                 t_we,
    output logic                 t_ack,
    output logic                 irq
);

    typedef enum logic {IDLE, ACK} state_t;

    state_t                state, state_nxt;
    logic [63:0]           mtime;
    logic [63:0]           mtimecmp;
    logic [1:0]            ctrl;
    logic [PRESCALE_W-1:0] prescale;
    logic [PRESCALE_W-1:0] pcnt;
    logic [2:0]            idx;
    logic                  access;
    logic                  wr;
    logic                  rd;
    logic                  tick;
    logic                  mtime_wr;
    logic [31:0]           rdata;
    logic [31:0]           prescale_ext;
    logic [31:0]           prescale_new;
    logic                  unused_adr;

`ifdef FWVEXRISC_WB_TIMER_SNAPSHOT_EN
    logic [31:0]           shadow;
`endif

    function automatic logic [31:0] merge(input logic [31:0] old_val,
                                          input logic [31:0] new_val,
                                          input logic [3:0]  sel);
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            res[8*i +: 8] = sel[i] ? new_val[8*i +: 8] : old_val[8*i +: 8];
        end
        return res;
    endfunction

    assign idx        = t_adr[4:2];
    assign unused_adr = ^{t_adr[ADR_WIDTH-1:5], t_adr[1:0]};

    assign access   = (state == IDLE) && t_cyc && t_stb;
    assign wr       = access && t_we;
    assign rd       = access && !t_we;
    assign tick     = ctrl[0] && (pcnt == prescale);
    // A bus write to either mtime half suppresses the tick for the whole counter.
    assign mtime_wr = wr && (idx == 3'd0 || idx == 3'd1);

    assign prescale_ext = 32'(prescale);
    assign prescale_new = merge(prescale_ext, t_dat_w, t_sel);

    always_comb begin
        state_nxt = state;
        t_ack     = 1'b0;
        case (state)
            IDLE: if (t_cyc && t_stb) state_nxt = ACK;
            ACK: begin
                t_ack     = t_cyc && t_stb;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        rdata = '0;
        case (idx)
            3'd0: rdata = mtime[31:0];
`ifdef FWVEXRISC_WB_TIMER_SNAPSHOT_EN
            3'd1: rdata = shadow;
`else
            3'd1: rdata = mtime[63:32];
`endif
            3'd2: rdata = mtimecmp[31:0];
            3'd3: rdata = mtimecmp[63:32];
            3'd4: rdata = {30'd0, ctrl};
            3'd5: rdata = prescale_ext;
            default: rdata = '0;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mtime <= '0;
        end else if (mtime_wr) begin
            if (idx == 3'd0) mtime[31:0]  <= merge(mtime[31:0], t_dat_w, t_sel);
            else             mtime[63:32] <= merge(mtime[63:32], t_dat_w, t_sel);
        end else if (tick) begin
            mtime <= mtime + 64'd1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pcnt <= '0;
        end else if (wr && idx == 3'd5) begin
            pcnt <= '0;
        end else if (ctrl[0]) begin
            pcnt <= tick ? '0 : pcnt + PRESCALE_W'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mtimecmp <= '1;
            ctrl     <= '0;
            prescale <= PRESCALE_RST;
        end else if (wr) begin
            case (idx)
                3'd2: mtimecmp[31:0]  <= merge(mtimecmp[31:0], t_dat_w, t_sel);
                3'd3: mtimecmp[63:32] <= merge(mtimecmp[63:32], t_dat_w, t_sel);
                3'd4: if (t_sel[0]) ctrl <= t_dat_w[1:0];
                3'd5: prescale <= prescale_new[PRESCALE_W-1:0];
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            t_dat_r <= '0;
        end else if (rd) begin
            t_dat_r <= rdata;
        end
    end

`ifdef FWVEXRISC_WB_TIMER_SNAPSHOT_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            shadow <= '0;
        end else if (rd && idx == 3'd0) begin
            shadow <= mtime[63:32];
        end
    end
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            irq <= 1'b0;
        end else begin
            irq <= ctrl[1] && (mtime >= mtimecmp);
        end
    end

endmodule

// File: tb/tb_fwvexrisc_wb_timer.sv
// Randomized bench for fwvexrisc_wb_timer against a transaction-level timer model, plus directed literal checks.
module tb_fwvexrisc_wb_timer;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] t_adr = '0;
    logic [31:0] t_dat_w = '0;
    logic [31:0] t_dat_r;
    logic        t_cyc = 1'b0;
    logic        t_stb = 1'b0;
    logic [3:0]  t_sel = '0;
    logic        t_we = 1'b0;
    logic        t_ack;
    logic        irq;

    int n_checks = 0;
    int n_err    = 0;
    logic chk_en = 1'b0;

    fwvexrisc_wb_timer dut (
        .clock(clock), .reset(reset), .t_adr(t_adr), .t_dat_w(t_dat_w), .t_dat_r(t_dat_r),
        .t_cyc(t_cyc), .t_stb(t_stb), .t_sel(t_sel), .t_we(t_we), .t_ack(t_ack), .irq(irq)
    );

    always #5 clock = ~clock;

    // Reference model: whole-register arithmetic, one access outstanding at most.
    logic [63:0] m_mtime, m_cmp;
    logic [1:0]  m_ctrl;
    logic [15:0] m_pre, m_pcnt;
    logic [31:0] m_dat, m_shadow;
    logic        m_busy, m_irq;

    function automatic logic [31:0] m_read(input int i);
        case (i)
            0: return m_mtime[31:0];
`ifdef FWVEXRISC_WB_TIMER_SNAPSHOT_EN
            1: return m_shadow;
`else
            1: return m_mtime[63:32];
`endif
            2: return m_cmp[31:0];
            3: return m_cmp[63:32];
            4: return {30'd0, m_ctrl};
            5: return {16'd0, m_pre};
            default: return 32'd0;
        endcase
    endfunction

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_mtime = '0; m_cmp = '1; m_ctrl = '0; m_pre = '0; m_pcnt = '0;
            m_dat = '0; m_shadow = '0; m_busy = 1'b0; m_irq = 1'b0;
        end else begin
            bit acc, tick, wr_time;
            int i;
            acc     = !m_busy && t_cyc && t_stb;
            i       = int'(t_adr[4:2]);
            wr_time = acc && t_we && (i < 2);
            tick    = m_ctrl[0] && (m_pcnt == m_pre);
            m_irq   = m_ctrl[1] && (m_mtime >= m_cmp);
            if (acc && !t_we) begin
                m_dat = m_read(i);
                if (i == 0) m_shadow = m_mtime[63:32];
            end
            if (m_ctrl[0]) m_pcnt = tick ? 16'd0 : m_pcnt + 16'd1;
            if (tick && !wr_time) m_mtime = m_mtime + 64'd1;
            if (acc && t_we) begin
                for (int b = 0; b < 4; b++) begin
                    if (t_sel[b]) begin
                        case (i)
                            0, 1: m_mtime[32*i + 8*b +: 8] = t_dat_w[8*b +: 8];
                            2, 3: m_cmp[32*(i-2) + 8*b +: 8] = t_dat_w[8*b +: 8];
                            4: if (b == 0) m_ctrl = t_dat_w[1:0];
                            5: if (b < 2) m_pre[8*b +: 8] = t_dat_w[8*b +: 8];
                            default: ;
                        endcase
                    end
                end
                if (i == 5) m_pcnt = '0;
            end
            m_busy = acc;
        end
    end

    always @(negedge clock) begin
        if (chk_en) begin
            logic exp_ack;
            exp_ack = m_busy && t_cyc && t_stb && !reset;
            n_checks++;
            if (t_ack !== exp_ack) begin
                n_err++;
                $display("FAIL model_ack t=%0t got=%b exp=%b", $time, t_ack, exp_ack);
            end
            n_checks++;
            if (irq !== m_irq) begin
                n_err++;
                $display("FAIL model_irq t=%0t got=%b exp=%b", $time, irq, m_irq);
            end
            n_checks++;
            if (t_dat_r !== m_dat) begin
                n_err++;
                $display("FAIL model_dat t=%0t got=%h exp=%h", $time, t_dat_r, m_dat);
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", name, act, exp);
        end
    endtask

    // Starts just after a posedge, returns just after the posedge that ends the ack cycle.
    task automatic wb(input logic we, input int i, input logic [3:0] sel,
                      input logic [31:0] dat, output logic [31:0] rdat);
        bit seen = 0;
        t_cyc = 1'b1; t_stb = 1'b1; t_we = we; t_sel = sel;
        t_adr = 32'(i) << 2; t_dat_w = dat;
        rdat = 'x;
        for (int n = 0; n < 4 && !seen; n++) begin
            @(negedge clock);
            if (t_ack === 1'b1) begin
                seen = 1;
                rdat = t_dat_r;
            end
        end
        if (!seen) begin
            n_checks++; n_err++;
            $display("FAIL ack_timeout idx=%0d got=none exp=ack", i);
        end
        @(posedge clock); #1;
        t_cyc = 1'b0; t_stb = 1'b0; t_we = 1'b0;
    endtask

    task automatic wr(input int i, input logic [31:0] dat);
        logic [31:0] d;
        wb(1'b1, i, 4'hF, dat, d);
    endtask

    task automatic rd(input int i, output logic [31:0] d);
        wb(1'b0, i, 4'hF, 32'd0, d);
    endtask

    task automatic aborted(input int i, input logic we, input logic [31:0] dat);
        t_cyc = 1'b1; t_stb = 1'b1; t_we = we; t_sel = 4'hF;
        t_adr = 32'(i) << 2; t_dat_w = dat;
        @(posedge clock); #1;
        t_cyc = 1'b0; t_stb = 1'b0;
        @(posedge clock); #1;
    endtask

    initial begin
        logic [31:0] d;
        #1 reset = 1'b1;
        #20 reset = 1'b0;
        @(posedge clock); #1;
        chk_en = 1'b1;

        // Ack timing on a held PRESCALE read, with back-to-back repeat.
        t_cyc = 1'b1; t_stb = 1'b1; t_we = 1'b0; t_sel = 4'h0; t_adr = 32'h14;
        @(negedge clock); check("ack_c1", t_ack, 0);
        @(negedge clock); check("ack_c2", t_ack, 1); check("pre_rst", t_dat_r, 0);
        @(negedge clock); check("ack_c3", t_ack, 0);
        @(negedge clock); check("ack_c4", t_ack, 1);
        @(posedge clock); #1; t_cyc = 1'b0; t_stb = 1'b0;

        // Byte lanes.
        wb(1'b1, 2, 4'b0101, 32'hAABBCCDD, d);
        rd(2, d); check("bytelane", d, 32'hFFBBFFDD);
        wr(2, 32'hFFFFFFFF);

        // Reset mid-access with irq high and nonzero read data.
        wr(4, 32'd2); wr(2, 32'd0); wr(3, 32'd0);
        @(posedge clock); #1; check("irq_pre_rst", irq, 1);
        t_cyc = 1'b1; t_stb = 1'b1; t_we = 1'b0; t_adr = 32'h10;
        @(negedge clock); @(negedge clock);
        check("ack_pre_rst", t_ack, 1); check("dat_pre_rst", t_dat_r, 2);
        #2 reset = 1'b1;
        #1 check("rst_ack", t_ack, 0); check("rst_irq", irq, 0); check("rst_dat", t_dat_r, 0);
        t_cyc = 1'b0; t_stb = 1'b0;
        @(negedge clock); #2 reset = 1'b0;
        @(posedge clock); #1;
        rd(2, d); check("rst_cmp_lo", d, 32'hFFFFFFFF);
        rd(4, d); check("rst_ctrl", d, 0);

        // Prescale 3: 20 enabled edges give 5 ticks, then hold.
        wr(5, 32'd3); wr(0, 32'd0); wr(1, 32'd0); wr(4, 32'd1);
        repeat (19) @(posedge clock);
        #1 check("model_mtime5", m_mtime, 64'd5);
        wr(4, 32'd0);
        rd(0, d); check("presc_mtime", d, 32'd5);
        repeat (10) @(posedge clock);
        #1 rd(0, d); check("presc_hold", d, 32'd5);

        // Wrap and irq.
        wr(5, 32'd0); wr(0, 32'hFFFFFFFF); wr(1, 32'hFFFFFFFF);
        wr(3, 32'd0); wr(2, 32'd1); wr(4, 32'd3);
        rd(1, d); check("wrap_hi", d, 32'd0);
        check("wrap_irq", irq, 1);
        wr(3, 32'hFFFFFFFF); wr(2, 32'hFFFFFFFF);
        @(posedge clock); #1 check("irq_fall", irq, 0);
        wr(4, 32'd0);

        // Carry between LO and HI reads.
        wr(0, 32'hFFFFFFFE); wr(1, 32'd5); wr(4, 32'd1);
        rd(0, d); check("snap_lo", d, 32'hFFFFFFFF);
        rd(1, d);
`ifdef FWVEXRISC_WB_TIMER_SNAPSHOT_EN
        check("snap_hi", d, 32'd5);
`else
        check("snap_hi", d, 32'd6);
`endif
        wr(4, 32'd0);

        // Randomized traffic, checked every cycle against the model.
        for (int n = 0; n < 400; n++) begin
            int r, i;
            logic [31:0] dat;
            r = $urandom_range(0, 9);
            i = $urandom_range(0, 7);
            case ($urandom_range(0, 3))
                0: dat = 32'd0;
                1: dat = 32'hFFFFFFFF;
                2: dat = 32'hFFFFFFFE;
                default: dat = $urandom;
            endcase
            if (i == 5) dat = $urandom_range(0, 3);
            if (i == 4) dat = $urandom_range(0, 3);
            if (r == 0) aborted(i, 1'($urandom_range(0, 1)), dat);
            else if (r == 1) begin
                repeat ($urandom_range(1, 4)) @(posedge clock);
                #1;
            end else wb(1'($urandom_range(0, 1)), i, 4'($urandom_range(0, 15)), dat, d);
        end

        @(posedge clock); #1;
        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
